aes_spi_host_seq: RTL and testbench
===================================

Name: aes_spi_host_seq

Overview:
- Synthesizable host-side sequencer directly upstream of master_full.
- Accepts one AES job per request: 128-bit text, key, key size and direction.
- Builds the 392-bit SPI frame and drives master_full through the full transfer sequence: load, dummy/wait transfers, result read-back.
- Returns the 128-bit result and a status code; replaces the bench-only wrapper FSM with reusable RTL.

Parameters:
- ENC_WAIT_XFERS, 1, dummy transfers between load and read-back for encryption.
- DEC_WAIT_XFERS, 2, dummy transfers between load and read-back for decryption.
- TIMEOUT_CYCLES, 65535, max clk cycles waiting for m_done on any single transfer.
- CNT_W, 16, width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  job request.
- req_ready  out  1  high in IDLE only.
- req_decrypt  in  1  0=encrypt, 1=decrypt; selects the wait-transfer count.
- req_text  in  128  plaintext or ciphertext.
- req_key  in  256  key, MSB-aligned; unused LSBs are don't-care.
- req_key_size  in  8  key length in bytes: 16, 24 or 32.
- resp_valid  out  1  result available; held until resp_ready.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  128  result text.
- resp_status  out  2  00 ok, 01 bad key size, 10 timeout.
- m_start  out  1  one-cycle start pulse to master_full.
- m_data_in  out  392  frame to master_full.
- m_done  in  1  one-cycle transfer-complete pulse from master_full.
- m_data_out  in  392  frame received by master_full.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: req_ready=0 during reset and 1 after; resp_valid=0; resp_data=0; resp_status=0; m_start=0; m_data_in=0; busy=0; FSM in IDLE; all counters 0.
- Load frame layout: m_data_in[391:264]=text, [263:256]=key_size, [255:0]=key.
- Dummy frames are all-zero.
- Result extraction: resp_data = m_data_out[383:256], captured on the read-back m_done.
- FSM states:
  - IDLE: req_ready=1. On req_valid:
    - key_size not in {16,24,32}: go to RESP with status 01; no SPI activity.
    - Otherwise: latch frame; set xfer_left = WAIT_XFERS+1 (selected by req_decrypt); go to START.
  - START: m_start=1 for exactly one cycle; m_data_in stable from this cycle through m_done; clear timer; go to WAIT.
  - WAIT: increment timer each cycle.
    - m_done and xfer_left==0: capture resp_data; status 00; go to RESP.
    - m_done and xfer_left>0: decrement xfer_left; load zero frame; go to START.
    - Timer reaches TIMEOUT_CYCLES before m_done: status 10; resp_data=0; go to RESP.
  - RESP: resp_valid=1. On resp_ready: go to IDLE, drop resp_valid.
- Latency: a request is accepted the cycle req_valid&&req_ready; the first m_start follows exactly one cycle later; consecutive transfers are separated by exactly one START cycle after m_done.
- m_done outside WAIT is ignored.
- m_done in the same cycle as timeout expiry: m_done wins.
- req_valid while busy is ignored (req_ready=0).
- Reset mid-job: FSM returns to IDLE the next edge with m_start=0 and resp_valid=0; the job is lost, no response. master_full shares reset.
- Total SPI transfers per job: encrypt 2+ENC_WAIT_XFERS=3; decrypt 2+DEC_WAIT_XFERS=4.

Decomposition:
- Package aes_spi_pkg:
  - FSM state encodings.
  - Frame field bounds: TEXT_MSB=391, KSZ_MSB=263, KEY_MSB=255, RES_MSB=383.
  - Key-size constants 8'd16/24/32.
  - Status codes.
  - FRAME_W=392.
- One sub-module: aes_xfer_timer (clear, enable, expired flag; CNT_W counter).

Test Plan:
- Encrypt AES-128: text 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, size 16, with master_full+AES -> 3 m_start pulses; resp_data=69c4e0d86a7b0430d8cdb78070b4c55a, status 00.
- Encrypt AES-192 (key 00..17, size 24) -> dda97ca4864cdfe06eaf70a0ec0d7191; encrypt AES-256 (key 00..1f, size 32) -> 8ea2b7ca516745bfeafc49904b496089.
- Decrypt AES-256 with 8ea2b7ca516745bfeafc49904b496089 -> 4 m_start pulses; resp_data=00112233445566778899aabbccddeeff, status 00.
- Key size 20 -> resp_valid next cycle, status 01, m_start never asserted.
- Stub master never asserts m_done, TIMEOUT_CYCLES=100 -> status 10 exactly 100 cycles after the first m_start; hold resp_ready low 5 cycles -> resp_valid held stable.
- Assert reset in WAIT of the second transfer -> next cycle IDLE, busy=0, no resp_valid; a following valid job completes correctly.

Source files
------------

// File: rtl/aes_spi_pkg.sv
// Shared encodings, frame field bounds and status codes for the AES SPI host sequencer.
package aes_spi_pkg;

    localparam int unsigned FRAME_W  = 392;
    localparam int unsigned TEXT_W   = 128;
    localparam int unsigned KEY_W    = 256;
    localparam int unsigned KSZ_W    = 8;
    localparam int unsigned STAT_W   = 2;

    localparam int unsigned TEXT_MSB = 391;
    localparam int unsigned KSZ_MSB  = 263;
    localparam int unsigned KEY_MSB  = 255;
    localparam int unsigned RES_MSB  = 383;

    localparam logic [KSZ_W-1:0] KSZ_128 = 8'd16;
    localparam logic [KSZ_W-1:0] KSZ_192 = 8'd24;
    localparam logic [KSZ_W-1:0] KSZ_256 = 8'd32;

    localparam logic [STAT_W-1:0] STAT_OK      = 2'b00;
    localparam logic [STAT_W-1:0] STAT_BAD_KEY = 2'b01;
    localparam logic [STAT_W-1:0] STAT_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic key_size_ok(input logic [KSZ_W-1:0] ks);
        return (ks == KSZ_128) || (ks == KSZ_192) || (ks == KSZ_256);
    endfunction

endpackage

// File: rtl/aes_xfer_timer.sv
// Per-transfer watchdog: counts enabled cycles since the last clear and flags
// when the count is about to reach TIMEOUT_CYCLES.
module aes_xfer_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count saturates at the expiry point so a stalled enable cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_c_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The START cycle is counted, so expiry lands TIMEOUT_CYCLES after m_start.
    assign expired_c_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/aes_spi_host_seq.sv
// Host-side sequencer for master_full: frames one AES job, runs load, dummy and
// read-back transfers, and returns the result with a status code.
module aes_spi_host_seq
    import aes_spi_pkg::*;
#(
    parameter int unsigned ENC_WAIT_XFERS = 1,
    parameter int unsigned DEC_WAIT_XFERS = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_decrypt,
    input  logic [TEXT_W-1:0]    req_text,
    input  logic [KEY_W-1:0]     req_key,
    input  logic [KSZ_W-1:0]     req_key_size,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [TEXT_W-1:0]    resp_data,
    output logic [STAT_W-1:0]    resp_status,
    output logic                 m_start,
    output logic [FRAME_W-1:0]   m_data_in,
    input  logic                 m_done,
    input  logic [FRAME_W-1:0]   m_data_out,
    output logic                 busy
);

    localparam int unsigned XFER_W = 8;

    state_e              state_q, state_d;
    logic [XFER_W-1:0]   xfer_left_q, xfer_left_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [TEXT_W-1:0]   resp_data_q, resp_data_d;
    logic [STAT_W-1:0]   resp_status_q, resp_status_d;
    logic                m_start_q;
    logic                resp_valid_q;
    logic                req_ready_q;
    logic                busy_q;
    logic                tmr_clear_c;
    logic                tmr_en_c;
    logic                tmr_expired_c;
    logic                unused_rx_c;

    aes_xfer_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (tmr_clear_c),
        .enable_i    (tmr_en_c),
        .expired_c_o (tmr_expired_c)
    );

    // Only the result field of the returned frame carries information.
    assign unused_rx_c = ^{m_data_out[FRAME_W-1:RES_MSB+1], m_data_out[RES_MSB-TEXT_W:0]};

    always_comb begin
        state_d       = state_q;
        xfer_left_d   = xfer_left_q;
        frame_d       = frame_q;
        resp_data_d   = resp_data_q;
        resp_status_d = resp_status_q;
        tmr_clear_c   = 1'b0;
        tmr_en_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (!key_size_ok(req_key_size)) begin
                        resp_status_d = STAT_BAD_KEY;
                        resp_data_d   = '0;
                        state_d       = ST_RESP;
                    end else begin
                        frame_d[TEXT_MSB -: TEXT_W] = req_text;
                        frame_d[KSZ_MSB -: KSZ_W]   = req_key_size;
                        frame_d[KEY_MSB -: KEY_W]   = req_key;
                        xfer_left_d = req_decrypt ? XFER_W'(DEC_WAIT_XFERS + 1)
                                                  : XFER_W'(ENC_WAIT_XFERS + 1);
                        tmr_clear_c = 1'b1;
                        state_d     = ST_START;
                    end
                end
            end
            ST_START: begin
                tmr_en_c = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                tmr_en_c = 1'b1;
                // A completion in the expiry cycle still counts as success.
                if (m_done) begin
                    if (xfer_left_q == '0) begin
                        resp_data_d   = m_data_out[RES_MSB -: TEXT_W];
                        resp_status_d = STAT_OK;
                        state_d       = ST_RESP;
                    end else begin
                        xfer_left_d = xfer_left_q - XFER_W'(1);
                        frame_d     = '0;
                        tmr_clear_c = 1'b1;
                        state_d     = ST_START;
                    end
                end else if (tmr_expired_c) begin
                    resp_status_d = STAT_TIMEOUT;
                    resp_data_d   = '0;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            xfer_left_q   <= '0;
            frame_q       <= '0;
            resp_data_q   <= '0;
            resp_status_q <= '0;
            m_start_q     <= 1'b0;
            resp_valid_q  <= 1'b0;
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            xfer_left_q   <= xfer_left_d;
            frame_q       <= frame_d;
            resp_data_q   <= resp_data_d;
            resp_status_q <= resp_status_d;
            m_start_q     <= (state_d == ST_START);
            resp_valid_q  <= (state_d == ST_RESP);
            req_ready_q   <= (state_d == ST_IDLE);
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_status = resp_status_q;
    assign m_start     = m_start_q;
    assign m_data_in   = frame_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_aes_spi_host_seq.sv
// Directed bench for aes_spi_host_seq against a behavioural master_full stub
// that returns known AES results on the read-back transfer.
module tb_aes_spi_host_seq;

    localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K128    = {128'h000102030405060708090a0b0c0d0e0f, 128'h5555aaaa5555aaaa5555aaaa5555aaaa};
    localparam logic [255:0] K192    = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0123456789abcdef};
    localparam logic [255:0] K256    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    typedef struct packed {
        logic [127:0] data;
        logic [1:0]   status;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_decrypt;
    logic [127:0] req_text;
    logic [255:0] req_key;
    logic [7:0]   req_key_size;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] resp_data;
    logic [1:0]   resp_status;
    logic         m_start;
    logic [391:0] m_data_in;
    logic         m_done;
    logic         m_done_s = 1'b0;
    logic         tb_done;
    logic [391:0] m_data_out = '0;
    logic         busy;

    int           nvec = 0;
    int           nerr = 0;
    exp_t         sb[$];

    int           start_cnt = 0;
    logic [391:0] frame_log [16];
    int           stub_lat = 2;
    bit           stub_mute = 1'b0;
    int           stub_last = 2;
    logic [127:0] stub_result = '0;
    int           xidx = 0;
    bit           pend = 1'b0;
    int           dly = 0;

    always #5 clk = ~clk;

    assign m_done = m_done_s | tb_done;

    aes_spi_host_seq #(
        .ENC_WAIT_XFERS (1),
        .DEC_WAIT_XFERS (2),
        .TIMEOUT_CYCLES (100),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_decrypt  (req_decrypt),
        .req_text     (req_text),
        .req_key      (req_key),
        .req_key_size (req_key_size),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_status  (resp_status),
        .m_start      (m_start),
        .m_data_in    (m_data_in),
        .m_done       (m_done),
        .m_data_out   (m_data_out),
        .busy         (busy)
    );

    // master_full stand-in: m_done arrives stub_lat+2 cycles after each m_start.
    always @(posedge clk) begin
        m_done_s <= 1'b0;
        if (reset) begin
            pend <= 1'b0;
            dly  <= 0;
        end else if (m_start) begin
            start_cnt                <= start_cnt + 1;
            frame_log[start_cnt % 16] <= m_data_in;
            xidx                     <= (m_data_in != '0) ? 0 : xidx + 1;
            pend                     <= !stub_mute;
            dly                      <= stub_lat;
        end else if (pend) begin
            if (dly == 0) begin
                pend       <= 1'b0;
                m_done_s   <= 1'b1;
                m_data_out <= {8'hA5,
                               (xidx == stub_last) ? stub_result : {4{32'hBAD0_0000 | xidx}},
                               {8{32'hC3C3_5A5A}}};
            end else begin
                dly <= dly - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [391:0] obs, input logic [391:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic run_job(input string tag, input bit dec, input logic [127:0] text,
                           input logic [255:0] key, input logic [7:0] ks,
                           input logic [127:0] exp_data, input logic [1:0] exp_st,
                           input int exp_starts, input int exp_lat, input int hold);
        int           base;
        int           cyc;
        exp_t         e;
        logic [391:0] acc;
        e           = '0;
        base        = start_cnt;
        stub_last   = exp_starts - 1;
        stub_result = exp_data;
        sb.push_back('{data: exp_data, status: exp_st});
        chk({tag, "/req_ready"}, 392'(req_ready), 392'(1));
        req_valid    = 1'b1;
        req_decrypt  = dec;
        req_text     = text;
        req_key      = key;
        req_key_size = ks;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "/first_start"}, 392'(m_start), 392'(exp_starts > 0));
        chk({tag, "/busy"}, 392'(busy), 392'(1));
        cyc = 1;
        while (resp_valid !== 1'b1 && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "/resp_valid"}, 392'(resp_valid), 392'(1));
        chk({tag, "/latency"}, 392'(cyc), 392'(exp_lat));
        if (sb.size() == 0) begin
            chk({tag, "/sb_empty"}, 392'(0), 392'(1));
        end else begin
            e = sb.pop_front();
            chk({tag, "/data"}, 392'(resp_data), 392'(e.data));
            chk({tag, "/status"}, 392'(resp_status), 392'(e.status));
        end
        chk({tag, "/starts"}, 392'(start_cnt - base), 392'(exp_starts));
        if (exp_starts > 0) begin
            chk({tag, "/load_frame"}, frame_log[base % 16], {text, ks, key});
            acc = '0;
            for (int i = 1; i < exp_starts; i++) acc |= frame_log[(base + i) % 16];
            chk({tag, "/dummy_frames"}, acc, 392'(0));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"}, 392'(resp_valid), 392'(1));
            chk({tag, "/hold_data"}, 392'({resp_data, resp_status}), 392'({e.data, e.status}));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "/release"}, 392'({resp_valid, busy, req_ready}), 392'(3'b001));
    endtask

    initial begin
        int base;
        int cyc;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_decrypt  = 1'b0;
        req_text     = '0;
        req_key      = '0;
        req_key_size = '0;
        resp_ready   = 1'b0;
        tb_done      = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst/req_ready", 392'(req_ready), 392'(0));
        chk("rst/outputs", 392'({resp_valid, resp_data, resp_status, m_start, busy}), 392'(0));
        chk("rst/m_data_in", m_data_in, 392'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst/ready_busy", 392'({req_ready, busy}), 392'(2'b10));

        // m_done while idle must not start anything
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        @(negedge clk);
        chk("idle_done/ignored", 392'({busy, m_start, resp_valid, req_ready}), 392'(4'b0001));

        run_job("enc128", 1'b0, PT, K128, 8'd16, CT128, 2'b00, 3, 16, 0);
        run_job("enc192", 1'b0, PT, K192, 8'd24, CT192, 2'b00, 3, 16, 0);
        run_job("enc256", 1'b0, PT, K256, 8'd32, CT256, 2'b00, 3, 16, 2);
        run_job("dec256", 1'b1, CT256, K256, 8'd32, PT, 2'b00, 4, 21, 0);
        run_job("badks20", 1'b0, PT, K128, 8'd20, 128'h0, 2'b01, 0, 1, 0);
        run_job("badks33", 1'b1, PT, K256, 8'd33, 128'h0, 2'b01, 0, 1, 0);

        stub_mute = 1'b1;
        run_job("timeout", 1'b0, PT, K128, 8'd16, 128'h0, 2'b10, 1, 101, 5);
        stub_mute = 1'b0;

        stub_lat = 97;
        run_job("done_at_expiry", 1'b0, PT, K128, 8'd16, CT128, 2'b00, 3, 301, 0);
        stub_lat = 98;
        run_job("done_after_expiry", 1'b0, PT, K128, 8'd16, 128'h0, 2'b10, 1, 101, 0);
        stub_lat = 2;

        // reset during the wait of the second transfer of a decrypt job
        base         = start_cnt;
        stub_last    = 3;
        stub_result  = PT;
        req_valid    = 1'b1;
        req_decrypt  = 1'b1;
        req_text     = CT256;
        req_key      = K256;
        req_key_size = 8'd32;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (start_cnt - base < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst/second_xfer", 392'(start_cnt - base), 392'(2));
        req_valid    = 1'b1;
        req_key_size = 8'd20;
        chk("midrst/busy_not_ready", 392'({busy, req_ready}), 392'(2'b10));
        reset = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("midrst/in_reset", 392'({busy, resp_valid, m_start, req_ready}), 392'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("midrst/ready", 392'({req_ready, busy}), 392'(2'b10));
        repeat (10) @(negedge clk);
        chk("midrst/job_lost", 392'({resp_valid, 32'(start_cnt - base)}), 392'({1'b0, 32'd2}));

        run_job("after_rst", 1'b0, PT, K128, 8'd16, CT128, 2'b00, 3, 16, 0);

        chk("sb/drained", 392'(sb.size()), 392'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

endmodule
